// File: rtl/fifo_pkg.sv
// Shared types and sizing for the extended FIFO pointer/status controller.
package fifo_pkg;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and status sequencing for a registered-read FIFO store.
// The storage array sits beside this block and follows wr_en/w_addr/r_addr.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int AF_LEVEL      = 12,
    parameter int AE_LEVEL      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     flush,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] w_addr,
    output logic [ADDRESS_WIDTH-1:0] r_addr,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int CW = ADDRESS_WIDTH + 1;
    typedef logic [ADDRESS_WIDTH-1:0] aptr_t;
    typedef logic [CW-1:0]            acnt_t;

    localparam acnt_t DEPTH_C = acnt_t'(2 ** ADDRESS_WIDTH);
    localparam acnt_t AF_C    = acnt_t'(AF_LEVEL);
    localparam acnt_t AE_C    = acnt_t'(AE_LEVEL);

    generate
        if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= 2 ** ADDRESS_WIDTH))) begin : g_bad_levels
            $error("fifo_ctrl: need AE_LEVEL < AF_LEVEL <= 2**ADDRESS_WIDTH");
        end
    endgenerate

    aptr_t        w_ptr_q, w_ptr_d;
    aptr_t        r_ptr_q, r_ptr_d;
    acnt_t        count_q, count_d;
    logic         rd_valid_q, rd_valid_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         wr_acc, rd_acc;
    fifo_status_t status;

    always_comb begin
        status              = '0;
        status.full         = (count_q == DEPTH_C);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= AF_C);
        status.almost_empty = (count_q <= AE_C);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    // A read frees a slot in the same edge, so a full FIFO still takes wr when rd is accepted.
    assign rd_acc = rd & ~status.empty;
    assign wr_acc = wr & (~status.full | rd_acc);

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            w_ptr_d     = w_ptr_q + aptr_t'(wr_acc);
            r_ptr_d     = r_ptr_q + aptr_t'(rd_acc);
            count_d     = count_q + acnt_t'(wr_acc) - acnt_t'(rd_acc);
            rd_valid_d  = rd_acc;
            overflow_d  = overflow_q | (wr & ~wr_acc);
            underflow_d = underflow_q | (rd & status.empty);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_en        = wr_acc & ~flush;
    assign w_addr       = w_ptr_q;
    assign r_addr       = r_ptr_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a queue-based occupancy/data model plus a small registered-read store.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, flush = 1'b0;
    logic       wr_en, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] w_addr, r_addr;
    logic [4:0] count;
    logic [7:0] wdata = 8'h00;
    logic [7:0] r_data;
    logic [7:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    int q[$];
    int wp = 0, rp = 0;
    bit m_ovf = 0, m_unf = 0, m_rv = 0;
    int m_data = 0;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDRESS_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .flush(flush),
        .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem[w_addr] <= wdata;
        r_data <= mem[r_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        wp = 0; rp = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":count"}, 32'(count), 32'(q.size()));
        chk({tag, ":full"}, 32'(full), 32'(q.size() == 16));
        chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ":afull"}, 32'(almost_full), 32'(q.size() >= 12));
        chk({tag, ":aempty"}, 32'(almost_empty), 32'(q.size() <= 4));
        chk({tag, ":w_addr"}, 32'(w_addr), 32'(wp));
        chk({tag, ":r_addr"}, 32'(r_addr), 32'(rp));
        chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ":unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(m_rv));
        if (m_rv) chk({tag, ":r_data"}, 32'(r_data), 32'(m_data));
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input string tag, input bit w, input bit r, input bit f, input logic [7:0] d);
        bit m_full, m_empty, racc, wacc;
        wr = w; rd = r; flush = f; wdata = d;
        m_full  = (q.size() == 16);
        m_empty = (q.size() == 0);
        racc = r && !m_empty;
        wacc = w && (!m_full || racc);
        #1;
        chk({tag, ":wr_en"}, 32'(wr_en), 32'(wacc && !f));
        @(posedge clk);
        #1;
        if (f) begin
            model_clear();
        end else begin
            if (racc) m_data = q.pop_front();
            if (wacc) q.push_back(int'(d));
            wp = (wp + int'(wacc)) % 16;
            rp = (rp + int'(racc)) % 16;
            m_ovf = m_ovf || (w && !wacc);
            m_unf = m_unf || (r && m_empty);
            m_rv  = racc;
        end
        check_state(tag);
        wr = 0; rd = 0; flush = 0;
    endtask

    initial begin
        #12;
        check_state("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        step("idle", 0, 0, 0, 8'h00);

        for (int i = 0; i < 16; i++) step("fill", 1, 0, 0, 8'(i + 8'h40));
        step("ovf17", 1, 0, 0, 8'hEE);
        step("flush1", 0, 0, 1, 8'h00);

        step("wA1", 1, 0, 0, 8'hA1);
        step("wB2", 1, 0, 0, 8'hB2);
        step("wC3", 1, 0, 0, 8'hC3);
        for (int i = 0; i < 3; i++) step("rd3", 0, 1, 0, 8'h00);
        step("unf4", 0, 1, 0, 8'h00);
        step("flush2", 0, 0, 1, 8'h00);

        for (int i = 0; i < 16; i++) step("fill2", 1, 0, 0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) step("fullrw", 1, 1, 0, 8'($urandom_range(0, 255)));
        step("flush3", 0, 0, 1, 8'h00);

        step("emptyrw", 1, 1, 0, 8'h5A);
        step("emptyrd", 0, 1, 0, 8'h00);

        step("unfset", 0, 1, 0, 8'h00);
        for (int i = 0; i < 7; i++) step("to7", 1, 0, 0, 8'(i + 8'h70));
        for (int i = 0; i < 10; i++) step("ovfset", 1, 0, 0, 8'hFF);
        while (q.size() > 7) step("drain7", 0, 1, 0, 8'h00);
        step("flushwr", 1, 0, 1, 8'h99);

        for (int i = 0; i < 300; i++)
            step("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 31) == 0), 8'($urandom_range(0, 255)));

        for (int i = 0; i < 5; i++) step("burst", 1, 0, 0, 8'($urandom_range(0, 255)));
        wr = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_clear();
        check_state("asyncrst");
        @(posedge clk); #1;
        wr = 1'b0;
        reset = 1'b1;
        step("postrst", 1, 0, 0, 8'h11);
        step("postrst_rd", 0, 1, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer and status controller for the extended FIFO. It sequences a 1-cycle-registered-read register file: it drives wr_en, w_addr and r_addr, and keeps an occupancy count. It also provides full/empty, almost-full/almost-empty thresholds, a 1-cycle read-valid strobe, sticky overflow/underflow flags and a synchronous flush. The top-level extended_fifo instantiates it beside the storage array.

Parameters:
ADDRESS_WIDTH, 4, pointer width; depth = 2**ADDRESS_WIDTH (16)
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
wr  input  1  write request, 1 cycle = 1 word
rd  input  1  read request, 1 cycle = 1 word
flush  input  1  synchronous clear of pointers, count and error flags
wr_en  output  1  storage write enable (combinational: wr accepted)
w_addr  output  ADDRESS_WIDTH  write pointer
r_addr  output  ADDRESS_WIDTH  read pointer (head)
rd_valid  output  1  storage r_data holds the popped word this cycle
full  output  1  count == 2**ADDRESS_WIDTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDRESS_WIDTH+1  current occupancy, 0..2**ADDRESS_WIDTH
overflow  output  1  sticky: wr seen while full and not accepted
underflow  output  1  sticky: rd seen while empty

Behaviour:
- Reset (reset=0, asynchronous): w_ptr=r_ptr=0, count=0, rd_valid=0, overflow=underflow=0. Outputs then read full=0, empty=1, almost_empty=1 (AE_LEVEL>=0) and almost_full=0.
- wr_acc = wr & (!full | rd_acc); rd_acc = rd & !empty. wr_en = wr_acc & !flush.
- Each edge (flush=0):
  - wr_acc: w_ptr += 1, wrapping modulo depth.
  - rd_acc: r_ptr += 1, wrapping.
  - count += wr_acc - rd_acc, in ADDRESS_WIDTH+1-bit arithmetic, never outside 0..depth.
- Read latency: the storage registers mem[r_addr] each edge. A read accepted at edge N presents its word on r_data after edge N. rd_valid is a registered copy of rd_acc, high for exactly the cycle after acceptance.
- Simultaneous wr & rd:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: both accepted. Write lands in the slot being vacated; count stays at depth; no overflow.
  - Empty: only the write is accepted; count becomes 1; underflow sets; rd_valid stays 0.
- Error flags:
  - wr while full without rd: wr ignored, overflow <= 1.
  - rd while empty: underflow <= 1.
  - Both flags hold until flush or reset.
- flush=1 at an edge: pointers, count, overflow, underflow and rd_valid all go to 0. wr/rd in the same cycle are dropped and wr_en is forced 0. flush has priority over everything except reset.
- Reset mid-operation: immediate return to reset state; storage contents are irrelevant because empty=1.
- Status outputs are combinational from registered count (no extra latency).
- Elaboration check: AE_LEVEL < AF_LEVEL <= 2**ADDRESS_WIDTH; otherwise $error.

Decomposition:
- Package fifo_pkg:
  - ADDRESS_WIDTH default and DEPTH constant.
  - typedef ptr_t (ADDRESS_WIDTH bits) and cnt_t (ADDRESS_WIDTH+1 bits).
  - struct fifo_status_t {full, empty, almost_full, almost_empty, overflow, underflow}.
- No sub-module inside fifo_ctrl: the two pointers are trivial increments.
- The natural pairing is the wrapper extended_fifo, which instantiates fifo_ctrl plus the storage array.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, w_addr=r_addr=0, rd_valid=0, flags 0.
- 16 consecutive wr -> count reaches 16; full=1 after the 16th edge; almost_full=1 after the 12th write; w_addr wraps to 0. A 17th wr sets overflow=1 with count staying 16 and wr_en=0.
- Write 0xA1,0xB2,0xC3, then 3 rd pulses -> rd_valid high each following cycle; r_data=0xA1,0xB2,0xC3 in order; empty=1 after the third read. A 4th rd sets underflow=1 and rd_valid stays 0.
- Fill to 16, then wr&rd together for 20 cycles -> count stays 16, pointers wrap and stay equal, data order is preserved, overflow stays 0.
- Empty FIFO, wr&rd same cycle -> count=1, underflow=1, rd_valid=0 next cycle. The word is readable on the following rd.
- Count=7 with flags set, assert flush together with wr -> next cycle count=0, pointers 0, flags 0, wr_en was 0. Also pulse reset low mid-burst -> outputs are immediately in reset state, without waiting for an edge.
